alu_op_issuer: RTL and testbench

//  Initiator side of the ALU interface. Accepts one instruction opcode plus two 64-bit

---
 rtl/alu_op_issuer.sv | 109 ++++++++++
 tb/tb_alu_op_issuer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/alu_op_issuer.sv
// Initiator side of the ALU interface: accepts an opcode plus operands, drives the
// combinational ALU for one cycle and returns its result over a valid/ready handshake.
module alu_op_issuer #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned OPC_W  = 11
) (
  input  logic              CLK,
  input  logic              resetl,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPC_W-1:0]  in_opcode,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic [DATA_W-1:0] alu_busa,
  output logic [DATA_W-1:0] alu_busb,
  output logic [3:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_busw,
  input  logic              alu_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_zero,
  output logic              out_err
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  localparam logic [3:0] CtrlAnd   = 4'b0000;
  localparam logic [3:0] CtrlOr    = 4'b0001;
  localparam logic [3:0] CtrlAdd   = 4'b0010;
  localparam logic [3:0] CtrlSub   = 4'b0110;
  localparam logic [3:0] CtrlPassB = 4'b0111;

  state_e     state_q;
  logic [3:0] dec_ctrl;
  logic       dec_legal;

  always_comb begin
    dec_ctrl  = CtrlAnd;
    dec_legal = 1'b1;
    casez (in_opcode)
      11'b10001011000: dec_ctrl = CtrlAdd;
      11'b11001011000: dec_ctrl = CtrlSub;
      11'b10001010000: dec_ctrl = CtrlAnd;
      11'b10101010000: dec_ctrl = CtrlOr;
      11'b11111000010: dec_ctrl = CtrlAdd;   // LDUR address add
      11'b11111000000: dec_ctrl = CtrlAdd;   // STUR address add
      11'b1001000100?: dec_ctrl = CtrlAdd;
      11'b1101000100?: dec_ctrl = CtrlSub;
      11'b10110100???: dec_ctrl = CtrlPassB; // CBZ tests operand B
      default:         dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q    <= StIdle;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b0;
      out_err    <= 1'b0;
      alu_busa   <= '0;
      alu_busb   <= '0;
      alu_ctrl   <= CtrlAnd;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (dec_legal) begin
              alu_busa <= in_a;
              alu_busb <= in_b;
              alu_ctrl <= dec_ctrl;
              state_q  <= StExec;
            end else begin
              // Illegal opcodes never touch the ALU drive registers.
              out_result <= '0;
              out_zero   <= 1'b0;
              out_err    <= 1'b1;
              out_valid  <= 1'b1;
              state_q    <= StResp;
            end
          end
        end
        StExec: begin
          out_result <= alu_busw;
          out_zero   <= alu_zero;
          out_err    <= 1'b0;
          out_valid  <= 1'b1;
          state_q    <= StResp;
        end
        StResp: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state_q   <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench for alu_op_issuer with a behavioural combinational ALU on the far side.
module tb_alu_op_issuer;

  logic        CLK = 1'b0;
  logic        resetl;
  logic        in_valid, in_ready;
  logic [10:0] in_opcode;
  logic [63:0] in_a, in_b;
  logic [63:0] alu_busa, alu_busb, alu_busw;
  logic [3:0]  alu_ctrl;
  logic        alu_zero;
  logic        out_valid, out_ready;
  logic [63:0] out_result;
  logic        out_zero, out_err;

  int checks = 0;
  int failures = 0;
  int acc_cnt = 0;

  always #5 CLK = ~CLK;

  alu_op_issuer #(.DATA_W(64), .OPC_W(11)) dut (
    .CLK(CLK), .resetl(resetl),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_a(in_a), .in_b(in_b),
    .alu_busa(alu_busa), .alu_busb(alu_busb), .alu_ctrl(alu_ctrl),
    .alu_busw(alu_busw), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_err(out_err)
  );

  // Combinational ALU
  always_comb begin
    alu_busw = '0;
    case (alu_ctrl)
      4'b0000: alu_busw = alu_busa & alu_busb;
      4'b0001: alu_busw = alu_busa | alu_busb;
      4'b0010: alu_busw = alu_busa + alu_busb;
      4'b0110: alu_busw = alu_busa - alu_busb;
      4'b0111: alu_busw = alu_busb;
      default: alu_busw = '0;
    endcase
    alu_zero = (alu_busw == 64'd0);
  end

  always @(posedge CLK) if (resetl && in_valid && in_ready) acc_cnt <= acc_cnt + 1;

  typedef struct {
    logic [10:0] opc;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  ctrl;
    logic [63:0] res;
    logic        zero;
    logic        err;
    int          hold;
  } vec_t;

  localparam int NV = 9;
  vec_t v[NV];

  task automatic chk(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  task automatic wait_valid(input int max);
    int n = 0;
    while (!out_valid && n < max) begin
      @(posedge CLK); #1;
      n++;
    end
  endtask

  logic [63:0] prev_a, prev_b;
  logic [3:0]  prev_ctrl;
  int          base, n;

  initial begin
    v[0] = '{11'b10001011000, 64'd5,      64'd7,      4'b0010, 64'd12, 1'b0, 1'b0, 1}; // ADD
    v[1] = '{11'b11001011000, 64'h1234,   64'h1234,   4'b0110, 64'd0,  1'b1, 1'b0, 1}; // SUB
    v[2] = '{11'b10001010000, 64'hF0,     64'h0F,     4'b0000, 64'd0,  1'b1, 1'b0, 0}; // AND
    v[3] = '{11'b10101010000, 64'hA,      64'h5,      4'b0001, 64'hF,  1'b0, 1'b0, 4}; // ORR
    v[4] = '{11'b10110100101, 64'h55,     64'd0,      4'b0111, 64'd0,  1'b1, 1'b0, 4}; // CBZ
    v[5] = '{11'b11111111111, 64'd1,      64'd2,      4'b0000, 64'd0,  1'b0, 1'b1, 2}; // illegal
    v[6] = '{11'b11111000000, 64'h20,     64'h10,     4'b0010, 64'h30, 1'b0, 1'b0, 0}; // STUR
    v[7] = '{11'b11010001001, 64'd10,     64'd3,      4'b0110, 64'd7,  1'b0, 1'b0, 0}; // SUBI
    v[8] = '{11'b00000000000, 64'd9,      64'd9,      4'b0000, 64'd0,  1'b0, 1'b1, 1}; // illegal

    resetl = 1'b0; in_valid = 1'b0; in_opcode = '0; in_a = '0; in_b = '0; out_ready = 1'b0;
    #12;
    chk("rst_valid", 0, out_valid, 0);
    chk("rst_err",   0, out_err, 0);
    chk("rst_zero",  0, out_zero, 0);
    chk("rst_res",   0, out_result, 0);
    chk("rst_busa",  0, alu_busa, 0);
    chk("rst_busb",  0, alu_busb, 0);
    chk("rst_ctrl",  0, alu_ctrl, 0);
    @(negedge CLK); resetl = 1'b1;
    @(posedge CLK); #1;
    chk("rst_ready", 0, in_ready, 1);
    prev_a = '0; prev_b = '0; prev_ctrl = '0;

    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1; in_opcode = v[i].opc; in_a = v[i].a; in_b = v[i].b; out_ready = 1'b0;
      @(posedge CLK); #1;
      in_valid = 1'b0;
      if (!v[i].err) begin
        chk("ctrl", i, alu_ctrl, v[i].ctrl);
        chk("busa", i, alu_busa, v[i].a);
        chk("busb", i, alu_busb, v[i].b);
        chk("exec_valid", i, out_valid, 0);
        @(posedge CLK); #1;
        prev_a = v[i].a; prev_b = v[i].b; prev_ctrl = v[i].ctrl;
      end else begin
        chk("err_ctrl_held", i, alu_ctrl, prev_ctrl);
        chk("err_busa_held", i, alu_busa, prev_a);
        chk("err_busb_held", i, alu_busb, prev_b);
      end
      chk("valid",  i, out_valid, 1);
      chk("result", i, out_result, v[i].res);
      chk("zero",   i, out_zero, v[i].zero);
      chk("err",    i, out_err, v[i].err);
      chk("ready_busy", i, in_ready, 0);
      for (int k = 0; k < v[i].hold; k++) begin
        @(posedge CLK); #1;
        chk("hold_valid",  i, out_valid, 1);
        chk("hold_result", i, out_result, v[i].res);
        chk("hold_ready",  i, in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge CLK); #1;
      out_ready = 1'b0;
      chk("done_valid", i, out_valid, 0);
      chk("done_ready", i, in_ready, 1);
    end

    // Reset in the middle of EXEC drops the request.
    in_valid = 1'b1; in_opcode = 11'b10001011000; in_a = 64'd3; in_b = 64'd4;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    chk("mid_ctrl", 0, alu_ctrl, 4'b0010);
    #2 resetl = 1'b0;
    #1;
    chk("mid_rst_valid", 0, out_valid, 0);
    chk("mid_rst_ctrl",  0, alu_ctrl, 0);
    chk("mid_rst_busa",  0, alu_busa, 0);
    chk("mid_rst_res",   0, out_result, 0);
    @(negedge CLK); resetl = 1'b1;
    @(posedge CLK); #1;
    chk("mid_rel_ready", 0, in_ready, 1);
    chk("mid_rel_valid", 0, out_valid, 0);
    chk("mid_rel_ctrl",  0, alu_ctrl, 0);

    // Back-to-back with in_valid held high and out_ready held high.
    base = acc_cnt;
    in_valid = 1'b1; in_opcode = 11'b10010001000; in_a = '1; in_b = 64'd1; out_ready = 1'b1;
    n = 0;
    while (acc_cnt == base && n < 10) begin @(posedge CLK); #1; n++; end
    in_opcode = 11'b11111000010; in_a = 64'h100; in_b = 64'd8;
    wait_valid(10);
    chk("b2b0_valid",  0, out_valid, 1);
    chk("b2b0_result", 0, out_result, 0);
    chk("b2b0_zero",   0, out_zero, 1);
    n = 0;
    while (acc_cnt == base + 1 && n < 10) begin @(posedge CLK); #1; n++; end
    in_valid = 1'b0;
    chk("b2b1_ctrl", 1, alu_ctrl, 4'b0010);
    wait_valid(10);
    chk("b2b1_valid",  1, out_valid, 1);
    chk("b2b1_result", 1, out_result, 64'h108);
    chk("b2b1_zero",   1, out_zero, 0);
    @(posedge CLK); #1;
    out_ready = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("b2b_accepts", 0, acc_cnt - base, 2);
    chk("b2b_idle", 0, out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
